// File: rtl/iir_sample_feeder_if.sv
// Sample-stream handshake bundle between a producer and the IIR sample feeder.
interface iir_sample_feeder_if #(
  parameter int WD = 16
);
  logic [WD-1:0] data;
  logic          valid;
  logic          ready;

  modport master (output data, output valid, input ready);
  modport slave  (input data, input valid, output ready);
endinterface

// File: rtl/iir_sample_feeder.sv
// Buffers an input sample stream and releases one sample per programmable period
// as a data word plus one-cycle strobe; empty ticks are zero-stuffed to keep the rate uniform.
module iir_sample_feeder #(
  parameter int WD     = 16,
  parameter int DEPTH  = 8,
  parameter int DIV_WD = 16
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  iir_sample_feeder_if.slave         s_if,
  input  logic [DIV_WD-1:0]          div_i,
  input  logic                       clr_i,
  output logic [WD-1:0]              data_o,
  output logic                       en_o,
  output logic [$clog2(DEPTH):0]     level_o,
  output logic                       underrun_o,
  output logic                       overflow_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [WD-1:0]     mem_q [DEPTH];
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]     level_q, level_d;
  logic [DIV_WD-1:0] cnt_q, cnt_d;
  logic [WD-1:0]     data_q, data_d;
  logic              en_q, en_d;
  logic              und_q, und_d;
  logic              ovf_q, ovf_d;

  logic full, empty, push, pop, tick;

  // Ready depends only on registered occupancy, never on s_if.valid.
  assign full       = (level_q == LW'(DEPTH));
  assign empty      = (level_q == '0);
  assign s_if.ready = ~full;
  assign push       = s_if.valid & ~full;
  assign tick       = (cnt_q >= div_i);
  assign pop        = tick & ~empty;

  always_comb begin
    cnt_d    = cnt_q + DIV_WD'(1);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    data_d   = data_q;
    en_d     = 1'b0;
    if (tick) begin
      cnt_d  = '0;
      en_d   = 1'b1;
      data_d = empty ? '0 : mem_q[rd_ptr_q];
    end
    if (push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({push, pop})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase
    // A new set condition beats a simultaneous clear.
    und_d = (tick & empty) | (und_q & ~clr_i);
    ovf_d = (s_if.valid & full) | (ovf_q & ~clr_i);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      data_q   <= '0;
      en_q     <= 1'b0;
      und_q    <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      data_q   <= data_d;
      en_q     <= en_d;
      und_q    <= und_d;
      ovf_q    <= ovf_d;
    end
  end

  // Storage needs no reset: the pointers and level define what is valid.
  always_ff @(posedge clk_i) begin
    if (push) mem_q[wr_ptr_q] <= s_if.data;
  end

  assign data_o     = data_q;
  assign en_o       = en_q;
  assign level_o    = level_q;
  assign underrun_o = und_q;
  assign overflow_o = ovf_q;
endmodule
